// File: rtl/pp_hop_wr_pkg.sv
// Shared types and widths for the path-parser hop FIFO write side.
package pp_hop_wr_pkg;

  localparam int HOP_INFO_NBITS    = 16;
  localparam int PP_META_RCI_NBITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DRAIN = 2'd2
  } wr_state_t;

endpackage

// File: rtl/pp_hop_wr_if.sv
// Hop stream, ping-pong FIFO bank, parser release, meta and status signals.
interface pp_hop_wr_if
  import pp_hop_wr_pkg::*;
#(
  parameter int HOP_NBITS = HOP_INFO_NBITS,
  parameter int RCI_NBITS = PP_META_RCI_NBITS,
  parameter int CNT_NBITS = 16
) ();

  logic                 hop_in_valid;
  logic                 hop_in_ready;
  logic [HOP_NBITS-1:0] hop_in_data;
  logic                 hop_in_sop;
  logic                 hop_in_eop;
  logic [RCI_NBITS-1:0] hop_in_rci;
  logic                 hop_fifo_wr0;
  logic                 hop_fifo_wr1;
  logic [HOP_NBITS-1:0] hop_fifo_wdata0;
  logic [HOP_NBITS-1:0] hop_fifo_wdata1;
  logic                 hop_fifo_reset0;
  logic                 hop_fifo_reset1;
  logic                 hop_fifo_full0;
  logic                 hop_fifo_full1;
  logic                 hop_fifo_fullm10;
  logic                 hop_fifo_fullm11;
  logic                 parse_done0;
  logic                 parse_done1;
  logic                 pp_meta_valid;
  logic [RCI_NBITS-1:0] pp_meta_rci;
  logic [CNT_NBITS-1:0] orphan_cnt;
  logic [CNT_NBITS-1:0] sop_err_cnt;
  logic [CNT_NBITS-1:0] drop_cnt;

  modport master (
    input  hop_in_valid, hop_in_data, hop_in_sop, hop_in_eop, hop_in_rci,
    input  hop_fifo_full0, hop_fifo_full1, hop_fifo_fullm10, hop_fifo_fullm11,
    input  parse_done0, parse_done1,
    output hop_in_ready,
    output hop_fifo_wr0, hop_fifo_wr1, hop_fifo_wdata0, hop_fifo_wdata1,
    output hop_fifo_reset0, hop_fifo_reset1,
    output pp_meta_valid, pp_meta_rci, orphan_cnt, sop_err_cnt, drop_cnt
  );

  modport slave (
    output hop_in_valid, hop_in_data, hop_in_sop, hop_in_eop, hop_in_rci,
    output hop_fifo_full0, hop_fifo_full1, hop_fifo_fullm10, hop_fifo_fullm11,
    output parse_done0, parse_done1,
    input  hop_in_ready,
    input  hop_fifo_wr0, hop_fifo_wr1, hop_fifo_wdata0, hop_fifo_wdata1,
    input  hop_fifo_reset0, hop_fifo_reset1,
    input  pp_meta_valid, pp_meta_rci, orphan_cnt, sop_err_cnt, drop_cnt
  );

endinterface

// File: rtl/pp_hop_bank_ctl.sv
// Per-bank bookkeeping: busy flag, flush pulse, registered write strobe and
// the effective-full view that accounts for a write already in flight.
module pp_hop_bank_ctl (
  input  logic clk,
  input  logic rst,
  input  logic i_set_busy,
  input  logic i_wr_req,
  input  logic i_parse_done,
  input  logic i_full,
  input  logic i_fullm1,
  output logic o_busy,
  output logic o_wr,
  output logic o_fifo_reset,
  output logic o_eff_full
);

  logic r_busy;
  logic r_wr;
  logic r_reset;

  // Busy set wins over a same-cycle release; a release flushes and cancels the next write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_wr    <= 1'b0;
      r_reset <= 1'b0;
    end else begin
      r_busy  <= i_set_busy | (r_busy & ~i_parse_done);
      r_wr    <= i_wr_req & ~i_parse_done;
      r_reset <= i_parse_done;
    end
  end

  assign o_busy       = r_busy;
  assign o_wr         = r_wr;
  assign o_fifo_reset = r_reset;
  assign o_eff_full   = i_full | (r_wr & i_fullm1);

endmodule

// File: rtl/pp_hop_wr.sv
// Steers per-packet hop streams into alternating FIFO banks, issues one meta
// entry per packet and discards packet tails once the parser releases a bank.
module pp_hop_wr
  import pp_hop_wr_pkg::*;
#(
  parameter int HOP_NBITS = HOP_INFO_NBITS,
  parameter int RCI_NBITS = PP_META_RCI_NBITS,
  parameter int CNT_NBITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  pp_hop_wr_if.master bus
);

  wr_state_t            r_state;
  wr_state_t            w_state_nxt;
  logic                 r_wbank;
  logic                 w_wbank_nxt;
  logic [HOP_NBITS-1:0] r_wdata;
  logic                 r_meta_valid;
  logic [RCI_NBITS-1:0] r_meta_rci;
  logic [CNT_NBITS-1:0] r_orphan_cnt;
  logic [CNT_NBITS-1:0] r_sop_err_cnt;
  logic [CNT_NBITS-1:0] r_drop_cnt;

  logic [1:0] w_busy;
  logic [1:0] w_eff_full;
  logic [1:0] w_wr;
  logic [1:0] w_fifo_reset;
  logic [1:0] w_pd;
  logic [1:0] w_wr_req;
  logic [1:0] w_set_busy;
  logic       w_ready;
  logic       w_acc;
  logic       w_pd_sel;
  logic       w_write;
  logic       w_meta;
  logic       w_orphan;
  logic       w_sop_err;
  logic       w_drop;

  function automatic logic [CNT_NBITS-1:0] sat_inc(input logic [CNT_NBITS-1:0] v,
                                                   input logic en);
    return (en && (v != {CNT_NBITS{1'b1}})) ? v + {{(CNT_NBITS-1){1'b0}}, 1'b1} : v;
  endfunction

  assign w_pd     = {bus.parse_done1, bus.parse_done0};
  assign w_pd_sel = w_pd[r_wbank];
  assign w_ready  = ~rst & ((r_state == DRAIN) |
                    (~w_eff_full[r_wbank] & ((r_state == WRITE) | ~w_busy[r_wbank])));
  assign w_acc    = bus.hop_in_valid & w_ready;

  assign w_wr_req   = {w_write & r_wbank, w_write & ~r_wbank};
  assign w_set_busy = {w_meta & r_wbank, w_meta & ~r_wbank};

  pp_hop_bank_ctl u_bank0 (
    .clk(clk), .rst(rst), .i_set_busy(w_set_busy[0]), .i_wr_req(w_wr_req[0]),
    .i_parse_done(bus.parse_done0), .i_full(bus.hop_fifo_full0),
    .i_fullm1(bus.hop_fifo_fullm10), .o_busy(w_busy[0]), .o_wr(w_wr[0]),
    .o_fifo_reset(w_fifo_reset[0]), .o_eff_full(w_eff_full[0])
  );

  pp_hop_bank_ctl u_bank1 (
    .clk(clk), .rst(rst), .i_set_busy(w_set_busy[1]), .i_wr_req(w_wr_req[1]),
    .i_parse_done(bus.parse_done1), .i_full(bus.hop_fifo_full1),
    .i_fullm1(bus.hop_fifo_fullm11), .o_busy(w_busy[1]), .o_wr(w_wr[1]),
    .o_fifo_reset(w_fifo_reset[1]), .o_eff_full(w_eff_full[1])
  );

  // State and bank pointer register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_wbank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_wbank <= w_wbank_nxt;
    end
  end

  // Next state and per-beat actions; a release of the active bank diverts the rest to DRAIN
  always_comb begin
    w_state_nxt = r_state;
    w_wbank_nxt = r_wbank;
    w_write     = 1'b0;
    w_meta      = 1'b0;
    w_orphan    = 1'b0;
    w_sop_err   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_acc && bus.hop_in_sop) begin
          w_write = 1'b1;
          w_meta  = 1'b1;
          if (bus.hop_in_eop) begin
            w_wbank_nxt = ~r_wbank;
          end else begin
            w_state_nxt = WRITE;
          end
        end else begin
          w_orphan = w_acc;
        end
      end
      WRITE: begin
        w_sop_err = w_acc & bus.hop_in_sop;
        if (w_pd_sel) begin
          w_drop = w_acc;
          if (w_acc && bus.hop_in_eop) begin
            w_state_nxt = IDLE;
            w_wbank_nxt = ~r_wbank;
          end else begin
            w_state_nxt = DRAIN;
          end
        end else if (w_acc) begin
          w_write = 1'b1;
          if (bus.hop_in_eop) begin
            w_state_nxt = IDLE;
            w_wbank_nxt = ~r_wbank;
          end else begin
            w_state_nxt = WRITE;
          end
        end else begin
          w_state_nxt = WRITE;
        end
      end
      DRAIN: begin
        w_drop = w_acc;
        if (w_acc && bus.hop_in_eop) begin
          w_state_nxt = IDLE;
          w_wbank_nxt = ~r_wbank;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered beat data, meta entry and saturating status counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdata       <= {HOP_NBITS{1'b0}};
      r_meta_valid  <= 1'b0;
      r_meta_rci    <= {RCI_NBITS{1'b0}};
      r_orphan_cnt  <= {CNT_NBITS{1'b0}};
      r_sop_err_cnt <= {CNT_NBITS{1'b0}};
      r_drop_cnt    <= {CNT_NBITS{1'b0}};
    end else begin
      r_wdata       <= w_acc ? bus.hop_in_data : r_wdata;
      r_meta_valid  <= w_meta;
      r_meta_rci    <= w_meta ? bus.hop_in_rci : r_meta_rci;
      r_orphan_cnt  <= sat_inc(r_orphan_cnt, w_orphan);
      r_sop_err_cnt <= sat_inc(r_sop_err_cnt, w_sop_err);
      r_drop_cnt    <= sat_inc(r_drop_cnt, w_drop);
    end
  end

  assign bus.hop_in_ready    = w_ready;
  assign bus.hop_fifo_wr0    = w_wr[0];
  assign bus.hop_fifo_wr1    = w_wr[1];
  assign bus.hop_fifo_wdata0 = r_wdata;
  assign bus.hop_fifo_wdata1 = r_wdata;
  assign bus.hop_fifo_reset0 = w_fifo_reset[0];
  assign bus.hop_fifo_reset1 = w_fifo_reset[1];
  assign bus.pp_meta_valid   = r_meta_valid;
  assign bus.pp_meta_rci     = r_meta_rci;
  assign bus.orphan_cnt      = r_orphan_cnt;
  assign bus.sop_err_cnt     = r_sop_err_cnt;
  assign bus.drop_cnt        = r_drop_cnt;

endmodule
